fifo_rptr_empty: RTL and testbench

//  Read-domain pointer and empty-flag controller for the 16-bit async FIFO.

---
 rtl/fifo_rptr_empty.sv | 99 +++++++++
 tb/tb_fifo_rptr_empty.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rptr_empty.sv
// fifo_rptr_empty
// Read-side pointer and empty-flag controller for the dual-clock FIFO.
// Everything here is clocked by r_clk. The writer's Gray pointer is brought
// in through a flop chain. The block keeps a binary read pointer for the
// storage array and a Gray copy of it for the writer's full logic.
// It also produces empty, read-valid, occupancy and sticky underflow flags.
module fifo_rptr_empty #(
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              r_clk,
    input  logic              r_rst,
    input  logic              r_en,
    input  logic [ADDR_W:0]   g_wptr_async,
    output logic [ADDR_W:0]   b_rptr,
    output logic [ADDR_W:0]   g_rptr,
    output logic              empty,
    output logic              rd_valid,
    output logic [ADDR_W:0]   rd_level,
    output logic              underflow
);

    localparam int unsigned PW = ADDR_W + 1;

    // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
    function automatic logic [PW-1:0] f_gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b = '0;
        for (int unsigned i = 0; i < PW; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    logic [PW-1:0] r_wq [SYNC_STAGES];
    logic [PW-1:0] r_b_rptr;
    logic [PW-1:0] r_g_rptr;
    logic          r_empty;
    logic          r_rd_valid;
    logic [PW-1:0] r_rd_level;
    logic          r_underflow;

    logic          w_accept;
    logic [PW-1:0] w_wqs;
    logic [PW-1:0] w_wqs_bin;
    logic [PW-1:0] w_b_next;
    logic [PW-1:0] w_g_next;

    // Writer Gray pointer moves through SYNC_STAGES flops into r_clk.
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                r_wq[i] <= '0;
            end
        end else begin
            r_wq[0] <= g_wptr_async;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                r_wq[i] <= r_wq[i-1];
            end
        end
    end

    // Next-pointer arithmetic. Empty is judged against the post-read pointer
    // so that the flag and the pointer update on the same edge.
    always_comb begin
        w_wqs     = r_wq[SYNC_STAGES-1];
        w_wqs_bin = f_gray2bin(w_wqs);
        w_accept  = r_en & ~r_empty;
        w_b_next  = r_b_rptr + PW'(w_accept);
        w_g_next  = w_b_next ^ (w_b_next >> 1);
    end

    // Pointer, flag and occupancy registers.
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            r_b_rptr    <= '0;
            r_g_rptr    <= '0;
            r_empty     <= 1'b1;
            r_rd_valid  <= 1'b0;
            r_rd_level  <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_b_rptr    <= w_b_next;
            r_g_rptr    <= w_g_next;
            r_empty     <= (w_g_next == w_wqs);
            r_rd_valid  <= w_accept;
            r_rd_level  <= w_wqs_bin - w_b_next;
            r_underflow <= r_underflow | (r_en & r_empty);
        end
    end

    assign b_rptr    = r_b_rptr;
    assign g_rptr    = r_g_rptr;
    assign empty     = r_empty;
    assign rd_valid  = r_rd_valid;
    assign rd_level  = r_rd_level;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Bench for fifo_rptr_empty: a table of hand-computed vectors followed by
// model-driven corner-case sequences, both checked through a scoreboard queue.
module tb_fifo_rptr_empty;

    typedef struct {
        logic [3:0] b;
        logic [3:0] g;
        logic       e;
        logic       v;
        logic [3:0] lvl;
        logic       uf;
    } exp_t;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] gw;
        exp_t       x;
    } vec_t;

    logic       clk;
    logic       i_rst;
    logic       i_en;
    logic [3:0] i_gw;
    logic [3:0] o_b;
    logic [3:0] o_g;
    logic       o_e;
    logic       o_v;
    logic [3:0] o_lvl;
    logic       o_uf;

    int errors = 0;
    int checks = 0;

    exp_t sbq[$];

    // model state (two sync stages)
    int m_wq0, m_wq1, m_b, m_lvl;
    bit m_empty, m_valid, m_uf;

    fifo_rptr_empty #(.ADDR_W(3), .SYNC_STAGES(2)) dut (
        .r_clk        (clk),
        .r_rst        (i_rst),
        .r_en         (i_en),
        .g_wptr_async (i_gw),
        .b_rptr       (o_b),
        .g_rptr       (o_g),
        .empty        (o_e),
        .rd_valid     (o_v),
        .rd_level     (o_lvl),
        .underflow    (o_uf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic int gray_of(input int k);
        int n;
        n = k % 16;
        return n ^ (n >> 1);
    endfunction

    function automatic int bin_of_gray(input int g);
        logic [3:0] gv;
        logic [3:0] bv;
        gv = g[3:0];
        bv[3] = gv[3];
        for (int i = 2; i >= 0; i--) bv[i] = bv[i+1] ^ gv[i];
        return int'(bv);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance the model by one edge using the inputs applied to that edge.
    task automatic model_edge(input bit rst, input bit en, input int gw);
        int wqs, nb, ng;
        bit acc;
        if (rst) begin
            m_wq0 = 0; m_wq1 = 0; m_b = 0; m_lvl = 0;
            m_empty = 1; m_valid = 0; m_uf = 0;
        end else begin
            wqs   = m_wq1;
            acc   = en && !m_empty;
            m_uf  = m_uf || (en && m_empty);
            nb    = (m_b + (acc ? 1 : 0)) % 16;
            ng    = gray_of(nb);
            m_empty = (ng == wqs);
            m_lvl = (bin_of_gray(wqs) - nb + 16) % 16;
            m_valid = acc;
            m_b   = nb;
            m_wq1 = m_wq0;
            m_wq0 = gw;
        end
    endtask

    // Drive one cycle, push the expectation, then pop and compare after the edge.
    task automatic step(input string tag, input bit rst, input bit en, input int gw,
                        input bit use_tab, input exp_t tx);
        exp_t mx;
        exp_t px;
        @(negedge clk);
        i_rst = rst;
        i_en  = en;
        i_gw  = gw[3:0];
        @(posedge clk);
        model_edge(rst, en, gw);
        mx.b = m_b[3:0]; mx.g = gray_of(m_b) & 4'hF; mx.e = m_empty;
        mx.v = m_valid; mx.lvl = m_lvl[3:0]; mx.uf = m_uf;
        sbq.push_back(use_tab ? tx : mx);
        #1;
        px = sbq.pop_front();
        chk({tag, ".b_rptr"},    int'(o_b),   int'(px.b));
        chk({tag, ".g_rptr"},    int'(o_g),   int'(px.g));
        chk({tag, ".empty"},     int'(o_e),   int'(px.e));
        chk({tag, ".rd_valid"},  int'(o_v),   int'(px.v));
        chk({tag, ".rd_level"},  int'(o_lvl), int'(px.lvl));
        chk({tag, ".underflow"}, int'(o_uf),  int'(px.uf));
    endtask

    task automatic mstep(input string tag, input bit rst, input bit en, input int gw);
        exp_t dummy;
        dummy = '{default: '0};
        step(tag, rst, en, gw, 1'b0, dummy);
    endtask

    vec_t tab[13];

    initial begin
        int pulses;
        int prev_g;
        bit seen_wrap;

        i_rst = 1'b1; i_en = 1'b0; i_gw = 4'd0;
        m_wq0 = 0; m_wq1 = 0; m_b = 0; m_lvl = 0;
        m_empty = 1; m_valid = 0; m_uf = 0;

        //            rst en  gw      b     g     e  v  lvl   uf
        tab[0]  = '{1'b1, 1'b0, 4'd0, '{4'd0, 4'd0, 1, 0, 4'd0, 0}};
        tab[1]  = '{1'b0, 1'b0, 4'd1, '{4'd0, 4'd0, 1, 0, 4'd0, 0}};
        tab[2]  = '{1'b0, 1'b0, 4'd1, '{4'd0, 4'd0, 1, 0, 4'd0, 0}};
        tab[3]  = '{1'b0, 1'b0, 4'd1, '{4'd0, 4'd0, 0, 0, 4'd1, 0}};
        tab[4]  = '{1'b0, 1'b1, 4'd1, '{4'd1, 4'd1, 1, 1, 4'd0, 0}};
        tab[5]  = '{1'b0, 1'b0, 4'd1, '{4'd1, 4'd1, 1, 0, 4'd0, 0}};
        tab[6]  = '{1'b0, 1'b1, 4'd1, '{4'd1, 4'd1, 1, 0, 4'd0, 1}};
        tab[7]  = '{1'b0, 1'b0, 4'd1, '{4'd1, 4'd1, 1, 0, 4'd0, 1}};
        tab[8]  = '{1'b0, 1'b0, 4'd3, '{4'd1, 4'd1, 1, 0, 4'd0, 1}};
        tab[9]  = '{1'b0, 1'b0, 4'd3, '{4'd1, 4'd1, 1, 0, 4'd0, 1}};
        tab[10] = '{1'b0, 1'b0, 4'd3, '{4'd1, 4'd1, 0, 0, 4'd1, 1}};
        tab[11] = '{1'b0, 1'b1, 4'd3, '{4'd2, 4'd3, 1, 1, 4'd0, 1}};
        tab[12] = '{1'b1, 1'b0, 4'd3, '{4'd0, 4'd0, 1, 0, 4'd0, 0}};

        for (int i = 0; i < 13; i++) begin
            step($sformatf("tab%0d", i), tab[i].rst, tab[i].en, int'(tab[i].gw), 1'b1, tab[i].x);
        end

        // Writer laps the pointer space while the reader drains continuously.
        mstep("lap_rst", 1'b1, 1'b0, 0);
        pulses = 0; prev_g = 0; seen_wrap = 0;
        for (int k = 1; k <= 16; k++) begin
            for (int r = 0; r < 2; r++) begin
                mstep($sformatf("lap%0d", k), 1'b0, 1'b1, gray_of(k));
                if (o_v) pulses++;
                if (int'(o_g) != prev_g) begin
                    if (prev_g == 8 && int'(o_g) == 0) seen_wrap = 1;
                    prev_g = int'(o_g);
                end
            end
        end
        for (int d = 0; d < 6; d++) begin
            mstep("lap_drain", 1'b0, 1'b1, 0);
            if (o_v) pulses++;
            if (int'(o_g) != prev_g) begin
                if (prev_g == 8 && int'(o_g) == 0) seen_wrap = 1;
                prev_g = int'(o_g);
            end
        end
        chk("lap.pulses", pulses, 16);
        chk("lap.g_wrap_seen", int'(seen_wrap), 1);
        chk("lap.b_final", int'(o_b), 0);

        // Writer a full DEPTH ahead, then three reads.
        mstep("lvl_rst", 1'b1, 1'b0, 0);
        for (int c = 0; c < 4; c++) mstep("lvl_sync", 1'b0, 1'b0, 12);
        chk("lvl.full", int'(o_lvl), 8);
        for (int c = 0; c < 3; c++) mstep("lvl_rd", 1'b0, 1'b1, 12);
        chk("lvl.after3", int'(o_lvl), 5);
        chk("lvl.not_empty", int'(o_e), 0);

        // Last word read on the edge where a new write becomes visible.
        mstep("last_rst", 1'b1, 1'b0, 0);
        for (int c = 0; c < 4; c++) mstep("last_fill", 1'b0, 1'b0, 1);
        mstep("last_a", 1'b0, 1'b0, 3);
        mstep("last_b", 1'b0, 1'b0, 3);
        mstep("last_c", 1'b0, 1'b1, 3);
        chk("last.empty_held", int'(o_e), 0);
        chk("last.valid", int'(o_v), 1);
        mstep("last_d", 1'b0, 1'b1, 3);
        chk("last.next_valid", int'(o_v), 1);
        chk("last.b", int'(o_b), 2);

        // Reset in the middle of traffic.
        mstep("mid_uf", 1'b0, 1'b1, 3);
        mstep("mid_rst0", 1'b1, 1'b1, 3);
        chk("mid.b", int'(o_b), 0);
        chk("mid.empty", int'(o_e), 1);
        chk("mid.uf", int'(o_uf), 0);
        mstep("mid_rst1", 1'b1, 1'b1, 3);
        for (int c = 0; c < 5; c++) mstep("mid_post", 1'b0, (c == 4), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
